// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU and its command sequencer:
//   alu_op_t    - ALU opcode encoding (0 and 10..15 are illegal)
//   flags_t     - captured {N,Z,C,V} flag bundle
//   seq_state_t - sequencer FSM states
//   is_legal_op - opcode legality check (divide-by-zero is checked separately)
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD = 4'd1,
      OP_SUB = 4'd2,
      OP_MUL = 4'd3,
      OP_DIV = 4'd4,
      OP_AND = 4'd5,
      OP_OR  = 4'd6,
      OP_XOR = 4'd7,
      OP_SHL = 4'd8,
      OP_SHR = 4'd9
   } alu_op_t;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_STROBE  = 3'd2,
      ST_SETTLE  = 3'd3,
      ST_CAPTURE = 3'd4,
      ST_RESP    = 3'd5
   } seq_state_t;

   // True for opcodes the ALU implements.
   function automatic logic is_legal_op(input logic [3:0] op);
      return (op >= 4'(OP_ADD)) && (op <= 4'(OP_SHR));
   endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Command-side driver for the ALU. Accepts one operation per cmd handshake,
// drives registered operands/opcode, raises a clean start strobe, waits
// SETTLE_CYC cycles, captures result + NZCV and returns them on the rsp channel.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake; cmd_op/cmd_a/cmd_b payload
//   alu_a/alu_b/alu_op/alu_start  registered drive to the ALU
//   alu_result, alu_n/z/c/v       ALU outputs
//   rsp_valid/rsp_ready           response handshake; rsp_result/rsp_flags/rsp_err payload
//   op_count                      responses accepted since reset (wrapping)
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned SETTLE_CYC = 2,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_op,
   output logic             alu_start,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_n,
   input  logic             alu_z,
   input  logic             alu_c,
   input  logic             alu_v,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic [3:0]       rsp_flags,
   output logic             rsp_err,
   output logic [CNT_W-1:0] op_count
);

   localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   seq_state_t       state_q, state_d;
   logic [SET_W-1:0] settle_q, settle_d;
   logic             cmd_ready_d;
   logic [WIDTH-1:0] alu_a_d, alu_b_d;
   logic [3:0]       alu_op_d;
   logic             alu_start_d;
   logic             rsp_valid_d;
   logic [WIDTH-1:0] rsp_result_d;
   flags_t           rsp_flags_d;
   logic             rsp_err_d;
   logic [CNT_W-1:0] op_count_d;
   logic             cmd_ok_c;

   // A command is executed only if the opcode exists and is not a divide by zero.
   assign cmd_ok_c = is_legal_op(cmd_op) && !((cmd_op == 4'(OP_DIV)) && (cmd_b == '0));

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         settle_q   <= '0;
         cmd_ready  <= 1'b1;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_op     <= '0;
         alu_start  <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_flags  <= '0;
         rsp_err    <= 1'b0;
         op_count   <= '0;
      end else begin
         state_q    <= state_d;
         settle_q   <= settle_d;
         cmd_ready  <= cmd_ready_d;
         alu_a      <= alu_a_d;
         alu_b      <= alu_b_d;
         alu_op     <= alu_op_d;
         alu_start  <= alu_start_d;
         rsp_valid  <= rsp_valid_d;
         rsp_result <= rsp_result_d;
         rsp_flags  <= rsp_flags_d;
         rsp_err    <= rsp_err_d;
         op_count   <= op_count_d;
      end
   end

   // Next-state and next-output logic; every register holds by default.
   always_comb begin
      state_d      = state_q;
      settle_d     = settle_q;
      cmd_ready_d  = cmd_ready;
      alu_a_d      = alu_a;
      alu_b_d      = alu_b;
      alu_op_d     = alu_op;
      alu_start_d  = alu_start;
      rsp_valid_d  = rsp_valid;
      rsp_result_d = rsp_result;
      rsp_flags_d  = rsp_flags;
      rsp_err_d    = rsp_err;
      op_count_d   = op_count;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               cmd_ready_d = 1'b0;
               if (cmd_ok_c) begin
                  // Operands land while start is still low, so the ALU sees a clean edge.
                  alu_a_d     = cmd_a;
                  alu_b_d     = cmd_b;
                  alu_op_d    = cmd_op;
                  alu_start_d = 1'b0;
                  state_d     = ST_SETUP;
               end else begin
                  // Rejected command: answer immediately, leave the ALU alone.
                  rsp_result_d = '0;
                  rsp_flags_d  = '0;
                  rsp_err_d    = 1'b1;
                  rsp_valid_d  = 1'b1;
                  state_d      = ST_RESP;
               end
            end
         end
         ST_SETUP: begin
            alu_start_d = 1'b1;
            state_d     = ST_STROBE;
         end
         ST_STROBE: begin
            settle_d = SET_W'(SETTLE_CYC - 1);
            state_d  = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (settle_q == '0) begin
               // Sample while start is still high, i.e. while the ALU output is valid.
               rsp_result_d = alu_result;
               rsp_flags_d  = '{n: alu_n, z: alu_z, c: alu_c, v: alu_v};
               rsp_err_d    = 1'b0;
               alu_start_d  = 1'b0;
               state_d      = ST_CAPTURE;
            end else begin
               settle_d = settle_q - SET_W'(1);
            end
         end
         ST_CAPTURE: begin
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               op_count_d  = op_count + CNT_W'(1);
               cmd_ready_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            alu_start_d = 1'b0;
            rsp_valid_d = 1'b0;
            cmd_ready_d = 1'b1;
            state_d     = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural ALU beside the DUT, a
// transaction-level timing model of the sequencer, a per-cycle compare
// process, directed cases with literal expectations, then random traffic.
module tb_alu_op_sequencer;
   import alu_pkg::*;

   localparam int unsigned W  = 8;
   localparam int unsigned S  = 2;
   localparam int unsigned CW = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid, cmd_ready;
   logic [3:0]    cmd_op;
   logic [W-1:0]  cmd_a, cmd_b;
   logic [W-1:0]  alu_a, alu_b, alu_result;
   logic [3:0]    alu_op;
   logic          alu_start, alu_n, alu_z, alu_c, alu_v;
   logic          rsp_valid, rsp_ready, rsp_err;
   logic [W-1:0]  rsp_result;
   logic [3:0]    rsp_flags;
   logic [CW-1:0] op_count;

   int total = 0;
   int bad   = 0;

   alu_op_sequencer #(.WIDTH(W), .SETTLE_CYC(S), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
      .alu_result(alu_result), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_flags(rsp_flags), .rsp_err(rsp_err), .op_count(op_count)
   );

   initial forever #5 clk = ~clk;

   // Behavioural ALU: returns {N,Z,C,V,result}.
   function automatic logic [11:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [8:0]  w;
      logic [15:0] m;
      logic [7:0]  r;
      logic        c, v;
      r = 8'h00; c = 1'b0; v = 1'b0;
      case (op)
         4'd1: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
         4'd2: begin r = a - b; c = (a < b); v = (a[7] != b[7]) && (r[7] != a[7]); end
         4'd3: begin m = 16'(a) * 16'(b); r = m[7:0]; c = (m[15:8] != 8'h00); end
         4'd4: r = (b == 8'h00) ? 8'h00 : a / b;
         4'd5: r = a & b;
         4'd6: r = a | b;
         4'd7: r = a ^ b;
         4'd8: r = a << b[2:0];
         4'd9: r = a >> b[2:0];
         default: r = 8'h00;
      endcase
      return {r[7], (r == 8'h00), c, v, r};
   endfunction

   // The ALU output is only meaningful while start is high; otherwise it shows junk.
   logic [11:0] alu_out;
   assign alu_out = alu_start ? alu_f(alu_op, alu_a, alu_b) : 12'hA5A;
   assign {alu_n, alu_z, alu_c, alu_v, alu_result} = alu_out;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Transaction model: m_e counts clock edges since the accepting edge.
   logic         m_busy, m_err, chk_en;
   int           m_e, m_lat;
   logic [7:0]   m_res, m_a, m_b;
   logic [3:0]   m_flg, m_op;
   logic [CW-1:0] m_cnt;

   initial begin
      m_busy = 1'b0; m_err = 1'b0; chk_en = 1'b0; m_e = 0; m_lat = 0;
      m_res = '0; m_a = '0; m_b = '0; m_flg = '0; m_op = '0; m_cnt = '0;
      forever begin
         @(posedge clk);
         if (rst) begin
            m_busy = 1'b0; m_cnt = '0; m_a = '0; m_b = '0; m_op = '0;
            m_res = '0; m_flg = '0; m_err = 1'b0; chk_en = 1'b1;
         end else if (!m_busy) begin
            if (cmd_valid) begin
               m_busy = 1'b1;
               m_e    = 0;
               if (cmd_op >= 4'd1 && cmd_op <= 4'd9 && !(cmd_op == 4'd4 && cmd_b == 8'h00)) begin
                  m_lat = int'(S) + 3;
                  {m_flg, m_res} = alu_f(cmd_op, cmd_a, cmd_b);
                  m_err = 1'b0;
                  m_a = cmd_a; m_b = cmd_b; m_op = cmd_op;
               end else begin
                  m_lat = 0;
                  m_res = 8'h00; m_flg = 4'h0; m_err = 1'b1;
               end
            end
         end else if (m_e >= m_lat) begin
            if (rsp_ready) begin
               m_busy = 1'b0;
               m_cnt  = m_cnt + CW'(1);
            end
         end else begin
            m_e++;
         end
      end
   end

   // Per-cycle compare against the model, away from the active edge.
   initial begin
      logic exp_v, exp_s;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            exp_v = m_busy && (m_e >= m_lat);
            exp_s = m_busy && (m_lat != 0) && (m_e >= 1) && (m_e <= int'(S) + 1);
            chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
            chk("alu_start", 32'(alu_start), 32'(exp_s));
            chk("alu_a", 32'(alu_a), 32'(m_a));
            chk("alu_b", 32'(alu_b), 32'(m_b));
            chk("alu_op", 32'(alu_op), 32'(m_op));
            chk("op_count", 32'(op_count), 32'(m_cnt));
            if (exp_v) begin
               chk("rsp_result", 32'(rsp_result), 32'(m_res));
               chk("rsp_flags", 32'(rsp_flags), 32'(m_flg));
               chk("rsp_err", 32'(rsp_err), 32'(m_err));
            end
         end
      end
   end

   // Count rising edges of alu_start.
   int   rises = 0;
   logic start_prev = 1'b0;
   initial forever begin
      @(negedge clk);
      if (alu_start && !start_prev) rises++;
      start_prev = alu_start;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      int n;
      cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) chk("send_timeout", 32'(cmd_ready), 32'd1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!rsp_valid && lat < 50) begin
         tick();
         lat++;
      end
      if (lat >= 50) chk("rsp_timeout", 32'(rsp_valid), 32'd1);
   endtask

   task automatic handshake();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   initial begin
      int lat;
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
      tick(); tick();
      chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_op_count", 32'(op_count), 32'd0);
      chk("reset_alu_start", 32'(alu_start), 32'd0);
      rst = 1'b0;
      tick();

      // ADD 7F+01: overflow into the sign bit.
      rises = 0;
      send(4'd1, 8'h7F, 8'h01);
      wait_rsp(lat);
      chk("add_latency", 32'(lat), 32'd5);
      chk("add_result", 32'(rsp_result), 32'h80);
      chk("add_zcv", 32'(rsp_flags[2:0]), 32'b001);
      chk("add_start_rises", 32'(rises), 32'd1);
      repeat (10) tick();
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_result", 32'(rsp_result), 32'h80);
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      handshake();
      chk("add_count", 32'(op_count), 32'd1);

      // SUB 5-5 with rsp_ready held high.
      rsp_ready = 1'b1;
      send(4'd2, 8'h05, 8'h05);
      wait_rsp(lat);
      chk("sub_result", 32'(rsp_result), 32'h00);
      chk("sub_z", 32'(rsp_flags[2]), 32'd1);
      tick();
      rsp_ready = 1'b0;
      chk("sub_count", 32'(op_count), 32'd2);

      // Divide by zero: error, no strobe.
      rises = 0;
      send(4'd4, 8'h10, 8'h00);
      wait_rsp(lat);
      chk("div0_latency", 32'(lat), 32'd0);
      chk("div0_err", 32'(rsp_err), 32'd1);
      chk("div0_result", 32'(rsp_result), 32'd0);
      handshake();
      chk("div0_start_rises", 32'(rises), 32'd0);

      // Illegal opcode F.
      send(4'hF, 8'h12, 8'h34);
      wait_rsp(lat);
      chk("opf_err", 32'(rsp_err), 32'd1);
      chk("opf_flags", 32'(rsp_flags), 32'd0);
      handshake();
      chk("opf_count", 32'(op_count), 32'd4);

      // Reset while settling, then a fresh MUL 6*7.
      send(4'd1, 8'h03, 8'h04);
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_start", 32'(alu_start), 32'd0);
      chk("abort_valid", 32'(rsp_valid), 32'd0);
      chk("abort_count", 32'(op_count), 32'd0);
      send(4'd3, 8'h06, 8'h07);
      wait_rsp(lat);
      chk("mul_latency", 32'(lat), 32'd5);
      chk("mul_result", 32'(rsp_result), 32'h2A);
      handshake();
      chk("mul_count", 32'(op_count), 32'd1);

      // Random traffic checked by the model every cycle.
      for (int i = 0; i < 3000; i++) begin
         cmd_valid = ($urandom_range(0, 2) != 0);
         cmd_op    = 4'($urandom_range(0, 15));
         cmd_a     = 8'($urandom);
         cmd_b     = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      repeat (20) tick();
      rsp_ready = 1'b0;

      // Counter wrap after 2^CW accepted responses.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < (1 << CW); i++) begin
         send(4'd0, 8'h00, 8'h00);
         wait_rsp(lat);
         handshake();
         if (i == (1 << CW) - 2) chk("count_max", 32'(op_count), 32'((1 << CW) - 1));
      end
      chk("count_wrap", 32'(op_count), 32'd0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog.
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

endmodule
